// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch queue
package fetch_pkg;

    localparam logic [31:0] FQ_RESET_PC = 32'h0000_3000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fq_entry_t;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fq_state_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - memory request/response, IF/ID output and redirect signals
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          rsp_valid;
    logic [31:0]   rsp_ins;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_ins;
    logic [31:0]   out_pc_plus_4;
    logic          redirect;
    logic [31:0]   redirect_addr;
    logic [CW-1:0] count;

    modport master (
        output req_valid, req_addr, out_valid, out_ins, out_pc_plus_4, count,
        input  req_ready, rsp_valid, rsp_ins, out_ready, redirect, redirect_addr
    );

    modport slave (
        input  req_valid, req_addr, out_valid, out_ins, out_pc_plus_4, count,
        output req_ready, rsp_valid, rsp_ins, out_ready, redirect, redirect_addr
    );

endinterface

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - circular entry buffer with occupancy count and flush
module fq_storage
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fq_entry_t              push_data,
    input  logic                   pop,
    output fq_entry_t              head,
    output logic [$clog2(DEPTH):0] count,
    output logic [$clog2(DEPTH):0] count_next
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fq_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign head       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - credit-based instruction fetch queue with redirect flush
// Optional same-cycle response bypass when empty: FETCH_QUEUE_BYPASS_EN
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = FQ_RESET_PC
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master fq
);
    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);

    fq_state_t     state_q, state_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;

    logic          req_valid, accept;
    logic          rsp_take, rsp_drop, live_push, bypass;
    logic          out_valid, fire, st_push, st_pop;
    logic [CW-1:0] st_count, st_count_next;
    logic [CW:0]   sum_credit, sum_track;
    fq_entry_t     head, push_data;

    // Responses retire oldest-first: stale (dropped) requests always precede live ones.
    always_comb begin
        req_valid = (state_q == FETCH) && !reset;
        accept    = req_valid && fq.req_ready;
        rsp_take  = fq.rsp_valid && ((drop_q != '0) || (live_q != '0));
        rsp_drop  = rsp_take && (drop_q != '0);
        live_push = rsp_take && (drop_q == '0) && !fq.redirect;
`ifdef FETCH_QUEUE_BYPASS_EN
        bypass    = live_push && (st_count == '0);
`else
        bypass    = 1'b0;
`endif
        out_valid = (st_count != '0) || bypass;
        fire      = out_valid && fq.out_ready && !fq.redirect;
        st_push   = live_push && !(bypass && fire);
        st_pop    = fire && !bypass;
        push_data = '{pc: rsp_pc_q, ins: fq.rsp_ins};
    end

    always_comb begin
        drop_d     = drop_q;
        live_d     = live_q;
        req_addr_d = req_addr_q;
        rsp_pc_d   = rsp_pc_q;
        if (fq.redirect) begin
            // Everything outstanding, including a request accepted now, becomes stale.
            drop_d     = drop_q + live_q + CW'(accept) - CW'(rsp_take);
            live_d     = '0;
            req_addr_d = fq.redirect_addr;
            rsp_pc_d   = fq.redirect_addr;
        end else begin
            drop_d = drop_q - CW'(rsp_drop);
            live_d = live_q + CW'(accept) - CW'(rsp_take && !rsp_drop);
            if (accept)    req_addr_d = req_addr_q + 32'd4;
            if (live_push) rsp_pc_d   = rsp_pc_q + 32'd4;
        end
        sum_credit = {1'b0, live_d} + {1'b0, st_count_next};
        sum_track  = {1'b0, drop_d} + {1'b0, live_d};
        state_d    = ((sum_credit < DEPTH_W) && (sum_track < DEPTH_W)) ? FETCH : HOLD;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            req_addr_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
        end
    end

    fq_storage #(.DEPTH(DEPTH)) u_storage (
        .clock      (clock),
        .reset      (reset),
        .flush      (fq.redirect),
        .push       (st_push),
        .push_data  (push_data),
        .pop        (st_pop),
        .head       (head),
        .count      (st_count),
        .count_next (st_count_next)
    );

    always_comb begin
        fq.out_ins       = '0;
        fq.out_pc_plus_4 = '0;
        if (bypass) begin
            fq.out_ins       = fq.rsp_ins;
            fq.out_pc_plus_4 = rsp_pc_q + 32'd4;
        end else if (out_valid) begin
            fq.out_ins       = head.ins;
            fq.out_pc_plus_4 = head.pc + 32'd4;
        end
    end

    assign fq.req_valid = req_valid;
    assign fq.req_addr  = req_addr_q;
    assign fq.out_valid = out_valid;
    assign fq.count     = st_count;

endmodule
